// File: rtl/mean_pkg.sv
// Shared constants for the window-statistics blocks (mean, variance).
package mean_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WS_I_DEF = 8;
    localparam int WS_J_DEF = 8;

    // Number of bits needed to index n items; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the pairwise adder tree: IN_CNT operands of IN_W bits
// become IN_CNT/2 sums of IN_W+1 bits, so no level can overflow.
module adder_tree_stage #(
    parameter int IN_CNT = 2,
    parameter int IN_W   = 8
) (
    input  logic                               clk,
    input  logic [IN_CNT*IN_W-1:0]             operands_i,
    output logic [(IN_CNT/2)*(IN_W+1)-1:0]     sums_o
);

    localparam int OUT_CNT = IN_CNT / 2;
    localparam int OUT_W   = IN_W + 1;

    logic [OUT_CNT*OUT_W-1:0] sums_d, sums_q;

    // Add neighbouring operand pairs, zero-extended to the widened result.
    always_comb begin
        sums_d = '0;
        for (int k = 0; k < OUT_CNT; k++) begin
            sums_d[k*OUT_W +: OUT_W] = OUT_W'(operands_i[(2*k)*IN_W +: IN_W])
                                     + OUT_W'(operands_i[(2*k+1)*IN_W +: IN_W]);
        end
    end

    // Data-only register; qualification travels in the parent's valid pipe.
    always_ff @(posedge clk) begin
        sums_q <= sums_d;
    end

    assign sums_o = sums_q;

endmodule

// File: rtl/mean.sv
// Pipelined window mean: input register, clog2(N) adder-tree levels, then a
// divide/output register. One window per cycle, latency clog2(N)+2.
module mean
    import mean_pkg::*;
#(
    parameter int WS_I    = mean_pkg::WS_I_DEF,
    parameter int WS_J    = mean_pkg::WS_J_DEF,
    parameter int PIXEL_W = mean_pkg::PIXEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WS_I*WS_J*PIXEL_W-1:0]  values,
    input  logic                          input_valid,
    output logic [PIXEL_W-1:0]            mean_value,
    output logic                          output_valid
);

    localparam int N      = WS_I * WS_J;
    localparam int LEVELS = clog2(N);
    localparam int M      = 1 << LEVELS;      // operand count padded to a power of two
    localparam int SUM_W  = PIXEL_W + LEVELS;
    localparam int STAGES = LEVELS + 1;       // valid bits: input reg, tree levels, output reg

    logic [M*PIXEL_W-1:0] win_d, win_q;
    logic [STAGES:0]      vld_pipe_q;
    logic [SUM_W-1:0]     sum_last;
    logic [PIXEL_W-1:0]   quot;
    logic [PIXEL_W-1:0]   mean_d, mean_q;

    // Pad a non-power-of-two window with zero pixels so the tree stays balanced.
    always_comb begin
        win_d = '0;
        win_d[N*PIXEL_W-1:0] = values;
    end

    // Stage 0 input register (data only).
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    // Valid bit shifts alongside the data; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], input_valid};
        end
    end

    if (LEVELS == 0) begin : g_single
        assign sum_last = win_q;
    end else begin : g_tree
        for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int IN_CNT = M >> l;
            localparam int IN_W   = PIXEL_W + l;

            logic [IN_CNT*IN_W-1:0]         ops;
            logic [(IN_CNT/2)*(IN_W+1)-1:0] sums;

            if (l == 0) begin : g_first
                assign ops = win_q;
            end else begin : g_next
                assign ops = g_lvl[l-1].sums;
            end

            adder_tree_stage #(
                .IN_CNT (IN_CNT),
                .IN_W   (IN_W)
            ) u_stage (
                .clk        (clk),
                .operands_i (ops),
                .sums_o     (sums)
            );
        end
        assign sum_last = g_lvl[LEVELS-1].sums;
    end

    // Power-of-two windows divide by shifting; others use a truncating constant divide.
    if (M == N) begin : g_shift
        assign quot = PIXEL_W'(sum_last >> LEVELS);
    end else begin : g_div
        assign quot = PIXEL_W'(sum_last / SUM_W'(N));
    end

    // Load a new mean only for a valid sum; otherwise hold the last result.
    always_comb begin
        mean_d = mean_q;
        if (vld_pipe_q[LEVELS]) mean_d = quot;
    end

    // Output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mean_q <= '0;
        end else begin
            mean_q <= mean_d;
        end
    end

    assign mean_value   = mean_q;
    assign output_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_mean.sv
// Bench for mean (8x8 window, 8-bit pixels): window-level reference model with a
// per-cycle compare, plus directed windows with literal expected means.

// Free-running 50% duty clock for simulation.
module clk_generator #(
    parameter int PERIOD = 10
) (
    output logic sys_clk
);
    initial begin
        sys_clk = 1'b0;
        forever #(PERIOD/2) sys_clk = ~sys_clk;
    end
endmodule

module tb_mean;

    localparam int PW    = 8;
    localparam int N     = 64;
    localparam int LAT   = 8;
    localparam int DEPTH = 1024;

    logic            clk;
    logic            rst;
    logic            input_valid;
    logic [N*PW-1:0] values;
    logic [PW-1:0]   mean_value;
    logic            output_valid;

    clk_generator #(.PERIOD(10)) u_clk (.sys_clk(clk));

    mean #(.WS_I(8), .WS_J(8), .PIXEL_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .values       (values),
        .input_valid  (input_valid),
        .mean_value   (mean_value),
        .output_valid (output_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each accepted window schedules its mean for a given edge number.
    bit sched_v [DEPTH];
    int sched_m [DEPTH];
    int cyc   = 0;
    bit exp_v = 1'b0;
    int exp_m = 0;

    function automatic int model_mean(input logic [N*PW-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(v[k*PW +: PW]);
        return s / N;
    endfunction

    // Window-level model: accepted at edge c, visible after edge c+LAT-1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int i = cyc; i < DEPTH; i++) sched_v[i] <= 1'b0;
            exp_v <= 1'b0;
            exp_m <= 0;
        end else begin
            if (input_valid && (cyc + LAT - 1 < DEPTH)) begin
                sched_v[cyc + LAT - 1] <= 1'b1;
                sched_m[cyc + LAT - 1] <= model_mean(values);
            end
            exp_v <= sched_v[cyc];
            if (sched_v[cyc]) exp_m <= sched_m[cyc];
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            total++;
            if (output_valid !== exp_v || int'(mean_value) != exp_m) begin
                bad++;
                $display("FAIL cycle%0d: valid=%0b mean=%0d, want valid=%0b mean=%0d",
                         cyc, output_valid, mean_value, exp_v, exp_m);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int p);
        for (int k = 0; k < N; k++) values[k*PW +: PW] = PW'(p);
    endtask

    // Present the current window for one cycle and wait (bounded) for its result.
    task automatic run_win(input string name, input int want);
        int k;
        k = 0;
        input_valid = 1'b1;
        step();
        input_valid = 1'b0;
        for (int i = 2; i <= 30; i++) begin
            step();
            if (output_valid) begin
                k = i;
                break;
            end
        end
        check({name, "_lat"}, k, LAT);
        check(name, int'(mean_value), want);
        step();
        check({name, "_hold"}, int'(mean_value), want);
    endtask

    initial begin
        int k;
        int cnt;
        rst = 1'b0;
        input_valid = 1'b0;
        values = '0;

        // Reset state
        repeat (3) step();
        check("rst_valid", int'(output_valid), 0);
        check("rst_mean", int'(mean_value), 0);
        rst = 1'b1;
        repeat (2) step();

        // Constant 124 stream: first result after 8 cycles, then continuously valid
        fill(124);
        input_valid = 1'b1;
        k = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (output_valid && k == 0) k = i;
        end
        check("stream_lat", k, LAT);
        check("stream_valid", int'(output_valid), 1);
        check("stream_mean", int'(mean_value), 124);
        input_valid = 1'b0;
        repeat (10) step();

        // Floor of 124.5
        for (int p = 0; p < N; p++) values[p*PW +: PW] = (p < 32) ? 8'd124 : 8'd125;
        run_win("half", 124);
        fill(255);
        run_win("all255", 255);
        fill(0);
        run_win("all0", 0);
        // Spread 122..126, symmetric around 124 (sum 7936)
        for (int p = 0; p < N; p++) begin
            int d;
            d = (p / 2) % 3;
            values[p*PW +: PW] = PW'((p % 2 == 0) ? 124 + d : 124 - d);
        end
        run_win("spread", 124);
        // Ramp 0,3,..,189: sum 6048 -> 94.5
        for (int p = 0; p < N; p++) values[p*PW +: PW] = PW'(3 * p);
        run_win("ramp", 94);
        // Half 255 / half 0: 127.5
        for (int p = 0; p < N; p++) values[p*PW +: PW] = (p % 2 == 0) ? 8'd255 : 8'd0;
        run_win("alt", 127);

        // Back-to-back A, B, gap, C
        fill(10);  input_valid = 1'b1; step();
        fill(200); step();
        input_valid = 1'b0; step();
        fill(50);  input_valid = 1'b1; step();
        input_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (output_valid) begin
                k = i;
                break;
            end
        end
        check("b2b_lat", k, 4);
        check("b2b_a", int'(mean_value), 10);
        step();
        check("b2b_b_v", int'(output_valid), 1);
        check("b2b_b", int'(mean_value), 200);
        step();
        check("b2b_gap_v", int'(output_valid), 0);
        check("b2b_gap_hold", int'(mean_value), 200);
        step();
        check("b2b_c_v", int'(output_valid), 1);
        check("b2b_c", int'(mean_value), 50);
        repeat (4) step();

        // Mid-flight reset; the window presented during reset must be ignored too
        fill(77); input_valid = 1'b1; step();
        input_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0; fill(99); input_valid = 1'b1; step();
        rst = 1'b1; input_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (output_valid) cnt++;
            step();
        end
        check("flush_cnt", cnt, 0);
        check("flush_mean", int'(mean_value), 0);
        fill(33);
        run_win("post_rst", 33);

        // Mixed stream with gaps, checked by the model only
        for (int c = 0; c < 24; c++) begin
            for (int p = 0; p < N; p++) values[p*PW +: PW] = PW'((p * 7 + c * 13) % 256);
            input_valid = (c % 3 != 0);
            step();
        end
        input_valid = 1'b0;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mean.md
MEAN -- requirements
Module: mean

Interface
REQ-001 Parameter WS_I, default 8, window height in pixels.
REQ-002 Parameter WS_J, default 8, window width in pixels.
REQ-003 Parameter PIXEL_W, default 8, bits per unsigned pixel.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 values  input  WS_I*WS_J*PIXEL_W  packed window; pixel k occupies bits [PIXEL_W*k+PIXEL_W-1 : PIXEL_W*k], k = 0..N-1, where N = WS_I*WS_J.
REQ-007 input_valid  input  1  qualifies values for the current cycle.
REQ-008 mean_value  output  PIXEL_W  arithmetic mean of the accepted window.
REQ-009 output_valid  output  1  qualifies mean_value.

Function
REQ-010 mean_value SHALL equal floor(sum of the N unsigned pixels / N); for power-of-two N this is a right shift of the sum by log2(N).
REQ-011 Sum width SHALL be PIXEL_W + clog2(N) bits (14 for 8x8), so overflow is impossible; the result always fits in PIXEL_W bits.
REQ-012 Pipeline SHALL be stage 0 = input register, then clog2(N) pairwise adder-tree stages, then the divide/output register; latency is clog2(N)+2 cycles (8 for 8x8).
REQ-013 The block SHALL accept a new window every cycle (no backpressure); each cycle with input_valid=1 yields exactly one output_valid=1 cycle, exactly latency cycles later.
REQ-014 A valid bit SHALL travel with each pipeline stage; input_valid=0 cycles produce output_valid=0 cycles in the same order.
REQ-015 When input_valid is held high with constant values, output_valid SHALL stay high continuously from latency cycles after the first accepted cycle.
REQ-016 mean_value SHALL hold its last value while output_valid=0.
REQ-017 For non-power-of-two N, the last stage SHALL use a constant integer divide that truncates toward zero.

Reset
REQ-018 While rst=0 at a rising edge, all valid bits and mean_value SHALL be cleared to 0, and output_valid SHALL read 0 on the following cycle.
REQ-019 Reset asserted mid-operation SHALL discard every in-flight window; no output_valid is produced for them after reset is released.
REQ-020 A window presented in the same cycle that rst=0 SHALL be ignored.

Structure
REQ-021 A shared package SHALL hold PIXEL_W, the default window dimensions and a clog2 constant function, for reuse by mean and the companion variance block.
REQ-022 The adder-tree level SHALL be one sub-module, adder_tree_stage (halves the operand count and widens each operand by 1 bit, registered); mean instantiates it clog2(N) times.
REQ-023 clk_generator is a separate simulation-only module with a single output sys_clk, a free-running 50% duty clock with its period set by a parameter; it is not synthesizable and is not part of mean.

Verification
REQ-024 All 64 pixels = 124, input_valid held high -> output_valid rises 8 cycles after the first accepted cycle, mean_value = 124.
REQ-025 Window with 32 pixels = 124 and 32 pixels = 125 -> mean_value = 124 (floor of 124.5); all pixels = 255 -> 255; all pixels = 0 -> 0.
REQ-026 Window of pixels spread around 124 (e.g. 122..126, sum 7936) -> mean_value = 124.
REQ-027 Back-to-back windows A (all 10), B (all 200), a gap cycle, then C (all 50) -> outputs 10, 200, a gap cycle, then 50, on consecutive cycles starting at latency.
REQ-028 rst=0 for 1 cycle, 3 cycles after accepting a window -> no output_valid for that window; the next window still produces a correct output at full latency.
REQ-029 After any reset, check mean_value = 0 and output_valid = 0 until the first post-reset result.
